// File: rtl/irq_ctrl_pkg.sv
// ============================================================================
// Module  : irq_ctrl_pkg
// Brief   : Shared bus encodings, register map and state encoding for irq_ctrl
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package irq_ctrl_pkg;

    localparam int WORD_DATA = 32;
    localparam int IRQ_ID_W  = 5;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    localparam logic [2:0] IRQ_PENDING_ADDR  = 3'd0;
    localparam logic [2:0] IRQ_MASK_ADDR     = 3'd1;
    localparam logic [2:0] IRQ_TRIG_ADDR     = 3'd2;
    localparam logic [2:0] IRQ_CLAIM_ADDR    = 3'd3;
    localparam logic [2:0] IRQ_COMPLETE_ADDR = 3'd4;
    localparam logic [2:0] IRQ_STATUS_ADDR   = 3'd5;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_ASSERT  = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_e;

endpackage

`default_nettype wire

// File: rtl/irq_prio_enc.sv
// ============================================================================
// Module  : irq_prio_enc
// Brief   : Lowest-index-wins priority encoder; id = index+1, 0 when idle
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module irq_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC = 8
) (
    input  logic [N_SRC-1:0]    req_i,
    output logic                valid_o,
    output logic [IRQ_ID_W-1:0] id_o
);

    // Scan high to low so the lowest set index is the last one written
    always_comb begin
        id_o = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                id_o = IRQ_ID_W'(i + 1);
            end
        end
    end

    assign valid_o = |req_i;

endmodule

`default_nettype wire

// File: rtl/irq_ctrl.sv
// ============================================================================
// Module  : irq_ctrl
// Brief   : Pending/mask/trigger interrupt controller with claim/complete
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC = 8
) (
    input  logic                 clk,
    input  logic                 rest,
    input  logic                 Irq_cs,
    input  logic                 Irq_as,
    input  logic                 Irq_rw,
    output logic                 Irq_rdy,
    input  logic [2:0]           Irq_addr,
    input  logic [WORD_DATA-1:0] Irq_wr_data,
    output logic [WORD_DATA-1:0] Irq_rd_data,
    input  logic [N_SRC-1:0]     irq_src,
    output logic                 cpu_irq,
    output logic [IRQ_ID_W-1:0]  cpu_irq_id
);

    logic [N_SRC-1:0]     pend_q, pend_d, mask_q, trig_q, prev_q;
    irq_state_e           state_q;
    logic [IRQ_ID_W-1:0]  inserv_q;
    logic                 rdy_q, irq_q;
    logic [WORD_DATA-1:0] rd_data_q, rd_data_d;

    logic                 w_acc, w_rd, w_wr, w_valid, w_claim, w_complete;
    logic [N_SRC-1:0]     w_claim_clr, w_w1c, w_set;
    logic                 w_unused;

    assign w_acc = Irq_cs & Irq_as;
    assign w_rd  = w_acc & (Irq_rw == READ);
    assign w_wr  = w_acc & (Irq_rw == WRITE);

    irq_prio_enc #(
        .N_SRC   (N_SRC)
    ) u_prio_enc (
        .req_i   (pend_q & mask_q),
        .valid_o (w_valid),
        .id_o    (cpu_irq_id)
    );

    assign w_claim    = w_rd && (Irq_addr == IRQ_CLAIM_ADDR) && (state_q == IRQ_ASSERT) && w_valid;
    assign w_complete = w_wr && (Irq_addr == IRQ_COMPLETE_ADDR) && (state_q == IRQ_SERVICE) &&
                        (Irq_wr_data[IRQ_ID_W-1:0] == inserv_q);

    assign w_w1c = (w_wr && (Irq_addr == IRQ_PENDING_ADDR)) ? Irq_wr_data[N_SRC-1:0] : '0;
    assign w_set = irq_src & ~prev_q;

    always_comb begin
        w_claim_clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (w_claim && (cpu_irq_id == IRQ_ID_W'(i + 1))) begin
                w_claim_clr[i] = 1'b1;
            end
        end
    end

    // Edge bits: clears first, then a fresh edge re-sets; level bits follow the line
    assign pend_d = (trig_q & ((pend_q & ~(w_w1c | w_claim_clr)) | w_set)) |
                    (~trig_q & irq_src);

    always_comb begin
        rd_data_d = '0;
        case (Irq_addr)
            IRQ_PENDING_ADDR: rd_data_d = WORD_DATA'(pend_q);
            IRQ_MASK_ADDR:    rd_data_d = WORD_DATA'(mask_q);
            IRQ_TRIG_ADDR:    rd_data_d = WORD_DATA'(trig_q);
            IRQ_CLAIM_ADDR:   rd_data_d = (state_q == IRQ_ASSERT) ? WORD_DATA'(cpu_irq_id) : '0;
            IRQ_STATUS_ADDR:  rd_data_d = {25'b0, state_q, inserv_q};
            default:          rd_data_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        prev_q <= irq_src;
        if (rest) begin
            pend_q    <= '0;
            mask_q    <= '0;
            trig_q    <= '1;
            state_q   <= IRQ_IDLE;
            inserv_q  <= '0;
            irq_q     <= 1'b0;
            rdy_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            pend_q <= pend_d;
            rdy_q  <= w_acc;
            if (w_rd) begin
                rd_data_q <= rd_data_d;
            end
            if (w_wr && (Irq_addr == IRQ_MASK_ADDR)) begin
                mask_q <= Irq_wr_data[N_SRC-1:0];
            end
            if (w_wr && (Irq_addr == IRQ_TRIG_ADDR)) begin
                trig_q <= Irq_wr_data[N_SRC-1:0];
            end
            case (state_q)
                IRQ_IDLE: begin
                    if (w_valid) begin
                        state_q <= IRQ_ASSERT;
                        irq_q   <= 1'b1;
                    end
                end
                IRQ_ASSERT: begin
                    if (w_claim) begin
                        state_q  <= IRQ_SERVICE;
                        inserv_q <= cpu_irq_id;
                        irq_q    <= 1'b0;
                    end else if (!w_valid) begin
                        state_q <= IRQ_IDLE;
                        irq_q   <= 1'b0;
                    end
                end
                IRQ_SERVICE: begin
                    if (w_complete) begin
                        state_q  <= IRQ_IDLE;
                        inserv_q <= '0;
                    end
                end
                default: begin
                    state_q <= IRQ_IDLE;
                    irq_q   <= 1'b0;
                end
            endcase
        end
    end

    assign Irq_rdy     = rdy_q;
    assign Irq_rd_data = rd_data_q;
    assign cpu_irq     = irq_q;
    assign w_unused    = ^Irq_wr_data[WORD_DATA-1:N_SRC];

endmodule

`default_nettype wire
